// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM fade controller.
// Contents: channel mode encoding, breathe-direction encoding, a percent-of-period
// helper for the breathe floor/ceiling, and a parameter legality predicate.
package pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_FULL    = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Integer floor of period*pct/100, done in 64 bits so large periods cannot overflow.
  function automatic int unsigned pct_of(input int unsigned period, input int unsigned pct);
    logic [63:0] prod;
    prod = 64'(period) * 64'(pct);
    return 32'(prod / 64'd100);
  endfunction

  // True when the parameter set describes a legal controller.
  function automatic bit params_ok(input int unsigned cnt_w,
                                   input int unsigned period,
                                   input int unsigned n_ch,
                                   input int unsigned min_pct,
                                   input int unsigned max_pct,
                                   input int unsigned step_periods,
                                   input int unsigned stagger);
    bit ok;
    ok = 1'b1;
    if (cnt_w < 1 || cnt_w > 31)                   ok = 1'b0;
    if (period < 2)                                ok = 1'b0;
    if (64'(period) >= (64'd1 << cnt_w))           ok = 1'b0;
    if (n_ch < 1)                                  ok = 1'b0;
    if (min_pct >= max_pct || max_pct > 100)       ok = 1'b0;
    if (step_periods < 1)                          ok = 1'b0;
    if (stagger > 1)                               ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/pwm_fade_ramp.sv
// Shared triangular breathe ramp bouncing between LO and HI.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   tick_i         period boundary while enabled
//   ramp_o         registered ramp value
//   dir_o          registered ramp direction
//   ramp_nxt_c_o   combinational value the ramp takes at this edge (for duty latching)
module pwm_fade_ramp
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned LO           = 0,
  parameter int unsigned HI           = 1,
  parameter int unsigned STEP         = 1,
  parameter int unsigned STEP_PERIODS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  output logic [CNT_W-1:0] ramp_o,
  output dir_e             dir_o,
  output logic [CNT_W-1:0] ramp_nxt_c_o
);

  localparam int unsigned PS_W   = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [CNT_W:0] LO_W   = (CNT_W+1)'(LO);
  localparam logic [CNT_W:0] HI_W   = (CNT_W+1)'(HI);
  localparam logic [CNT_W:0] STEP_W = (CNT_W+1)'(STEP);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_PERIODS - 1);

  logic [PS_W-1:0]  ps_q, ps_d;
  logic [CNT_W-1:0] ramp_q, ramp_d;
  dir_e             dir_q, dir_d;
  logic             upd;
  logic [CNT_W:0]   up_sum;
  logic [CNT_W:0]   dn_lim;

  assign upd = tick_i && (ps_q == PS_LAST);

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q   <= '0;
      ramp_q <= CNT_W'(LO);
      dir_q  <= DIR_UP;
    end else begin
      ps_q   <= ps_d;
      ramp_q <= ramp_d;
      dir_q  <= dir_d;
    end
  end

  // Prescaler and direction FSM; comparisons carry one extra bit so ramp+STEP cannot wrap.
  always_comb begin
    ps_d   = ps_q;
    ramp_d = ramp_q;
    dir_d  = dir_q;
    up_sum = {1'b0, ramp_q} + STEP_W;
    dn_lim = LO_W + STEP_W;
    if (tick_i) begin
      ps_d = upd ? '0 : ps_q + 1'b1;
    end
    if (upd) begin
      if (dir_q == DIR_UP) begin
        if (up_sum >= HI_W) begin
          ramp_d = CNT_W'(HI);
          dir_d  = DIR_DOWN;
        end else begin
          ramp_d = up_sum[CNT_W-1:0];
        end
      end else begin
        if ({1'b0, ramp_q} <= dn_lim) begin
          ramp_d = CNT_W'(LO);
          dir_d  = DIR_UP;
        end else begin
          ramp_d = ramp_q - CNT_W'(STEP);
        end
      end
    end
  end

  assign ramp_o       = ramp_q;
  assign dir_o        = dir_q;
  assign ramp_nxt_c_o = ramp_d;

endmodule

// File: rtl/pwm_fade_multi.sv
// Multi-channel PWM generator for the LED bank: one shared period counter, N_CH
// comparators, per-channel OFF/STATIC/BREATHE/FULL, optional phase staggering.
// Duty values are double-buffered and only change at the period boundary.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   en           1 = run, 0 = freeze counter/ramp and force outputs low
//   mode         2 bits per channel (pwm_pkg::mode_e)
//   duty_in      CNT_W bits per channel, STATIC duty in clk cycles
//   pwm_out      registered PWM outputs
//   ramp_val     current shared breathe ramp value
//   period_tick  registered pulse in the cycle after cnt == PERIOD-1
module pwm_fade_multi
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned PERIOD       = 50_000,
  parameter int unsigned N_CH         = 8,
  parameter int unsigned MIN_PCT      = 1,
  parameter int unsigned MAX_PCT      = 70,
  parameter int unsigned STEP         = 1,
  parameter int unsigned STEP_PERIODS = 1,
  parameter int unsigned STAGGER      = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [2*N_CH-1:0]       mode,
  input  logic [N_CH*CNT_W-1:0]   duty_in,
  output logic [N_CH-1:0]         pwm_out,
  output logic [CNT_W-1:0]        ramp_val,
  output logic                    period_tick
);

  localparam int unsigned LO = pct_of(PERIOD, MIN_PCT);
  localparam int unsigned HI = pct_of(PERIOD, MAX_PCT);
  localparam int unsigned PH = (STAGGER != 0) ? (PERIOD / N_CH) : 0;
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W:0]   PERIOD_W = (CNT_W+1)'(PERIOD);

  if (!params_ok(CNT_W, PERIOD, N_CH, MIN_PCT, MAX_PCT, STEP_PERIODS, STAGGER)) begin : g_param_check
    $error("pwm_fade_multi: illegal parameter combination");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             boundary;
  logic             tick_q;
  logic [N_CH-1:0]  pwm_q, pwm_d;
  logic [CNT_W-1:0] ramp_q;
  logic [CNT_W-1:0] ramp_nxt;
  dir_e             ramp_dir_unused;

  assign boundary = en && (cnt_q == LAST_C);

  // Shared period counter, held while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      pwm_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= boundary;
      pwm_q  <= pwm_d;
    end
  end

  pwm_fade_ramp #(
    .CNT_W        (CNT_W),
    .LO           (LO),
    .HI           (HI),
    .STEP         (STEP),
    .STEP_PERIODS (STEP_PERIODS)
  ) u_ramp (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_i       (boundary),
    .ramp_o       (ramp_q),
    .dir_o        (ramp_dir_unused),
    .ramp_nxt_c_o (ramp_nxt)
  );

  // Per-channel duty buffer, phase offset and comparator.
  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    localparam int unsigned OFFS = i * PH;

    logic [CNT_W-1:0] duty_ch;
    logic [1:0]       mode_ch;
    logic [CNT_W-1:0] duty_src;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic [CNT_W:0]   ph_sum;
    logic [CNT_W-1:0] ph;

    assign duty_ch = duty_in[CNT_W*i +: CNT_W];
    assign mode_ch = mode[2*i +: 2];

    // Source sampled at the boundary; BREATHE takes the post-update ramp value.
    always_comb begin
      duty_src = '0;
      case (mode_e'(mode_ch))
        MODE_OFF:     duty_src = '0;
        MODE_STATIC:  duty_src = (duty_ch > PERIOD_C) ? PERIOD_C : duty_ch;
        MODE_BREATHE: duty_src = ramp_nxt;
        MODE_FULL:    duty_src = PERIOD_C;
        default:      duty_src = '0;
      endcase
      duty_act_d = boundary ? duty_src : duty_act_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) duty_act_q <= '0;
      else        duty_act_q <= duty_act_d;
    end

    // OFFS < PERIOD, so a single conditional subtract wraps the phase.
    assign ph_sum   = {1'b0, cnt_q} + (CNT_W+1)'(OFFS);
    assign ph       = (ph_sum >= PERIOD_W) ? CNT_W'(ph_sum - PERIOD_W) : CNT_W'(ph_sum);
    assign pwm_d[i] = en && (ph < duty_act_q);
  end

  assign pwm_out     = pwm_q;
  assign ramp_val    = ramp_q;
  assign period_tick = tick_q;

endmodule

// File: doc/pwm_fade_multi.md
Name: pwm_fade_multi

Overview:
Multi-channel PWM generator for the LED bank, the parametrised successor of the single-channel fade controller.
- One shared period counter drives N_CH comparators.
- Each channel is independently OFF, STATIC duty, BREATHE (shared triangular ramp between min/max percent) or FULL.
- Optional phase staggering spreads channel edges across the period to limit simultaneous LED switching current.
- Duty updates are double-buffered at period boundaries, so outputs never glitch.

Parameters:
CNT_W, 16, width of period counter, duty values and ramp
PERIOD, 50_000, PWM period in clk cycles (25 MHz / 500 Hz); 2 <= PERIOD < 2**CNT_W
N_CH, 8, number of PWM channels (>= 1)
MIN_PCT, 1, breathe floor in percent of PERIOD; LO = PERIOD*MIN_PCT/100, integer floor
MAX_PCT, 70, breathe ceiling in percent; HI = PERIOD*MAX_PCT/100; MIN_PCT < MAX_PCT <= 100
STEP, 1, ramp increment per ramp update
STEP_PERIODS, 1, PWM periods between ramp updates (>= 1)
STAGGER, 1, 1 = channel i phase-shifted by i*(PERIOD/N_CH) cycles; 0 = all aligned

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  1 = run; 0 = freeze and force outputs low
mode  in  2*N_CH  per-channel mode, bits [2i+1:2i]: 0 OFF, 1 STATIC, 2 BREATHE, 3 FULL
duty_in  in  N_CH*CNT_W  per-channel STATIC duty in clk cycles, bits [CNT_W*i +: CNT_W]
pwm_out  out  N_CH  registered PWM outputs
ramp_val  out  CNT_W  current shared breathe ramp value
period_tick  out  1  one-cycle pulse, registered, in the cycle after cnt == PERIOD-1

Behaviour:
- Reset (async): cnt=0, ramp=LO, dir=up, prescaler=0, all duty_act=0, pwm_out=0, period_tick=0.
- en=1: cnt increments each clk and wraps PERIOD-1 -> 0. Boundary = cycle with cnt == PERIOD-1.
- At the boundary, each duty_act[i] latches its source:
  - OFF: 0
  - STATIC: min(duty_in[i], PERIOD)
  - BREATHE: value ramp takes after this boundary's update
  - FULL: PERIOD
- Mid-period changes to mode or duty_in have no effect until the next boundary.
- Ramp prescaler counts boundaries. On every STEP_PERIODS-th boundary the ramp updates:
  - up: if ramp+STEP >= HI then ramp=HI, dir=down; else ramp += STEP.
  - down: if ramp <= LO+STEP then ramp=LO, dir=up; else ramp -= STEP.
  - Ramp arithmetic uses CNT_W+1 bits; the ramp never leaves [LO, HI].
- Channel phase: ph[i] = (cnt + i*PH) mod PERIOD, where PH = PERIOD/N_CH if STAGGER else 0. Computed by compare/subtract, no divider.
- pwm_out[i] is registered: (ph[i] < duty_act[i]), latency 1 clk from cnt.
  - duty_act = 0 gives constant low.
  - duty_act >= PERIOD gives constant high.
- en=0: cnt, prescaler, ramp and dir hold; pwm_out=0 and period_tick=0 from the next clk.
- en 0 -> 1: counting resumes from the held cnt. duty_act retains its values.
- Reset mid-operation returns every register to reset values immediately. The first boundary after release is at cnt = PERIOD-1.
- No combinational path from inputs to outputs.

Decomposition:
- Package pwm_pkg:
  - mode constants MODE_OFF/STATIC/BREATHE/FULL
  - function pct_of(period, pct) for LO/HI
  - elaboration-time parameter legality checks
- Sub-module pwm_fade_ramp:
  - inputs clk, rst_n, tick (boundary & en), LO, HI, STEP, STEP_PERIODS
  - outputs ramp, dir
- The per-channel comparator stays inline in a generate loop.

Test Plan (PERIOD=10, N_CH=4, MIN_PCT=10, MAX_PCT=70 -> LO=1, HI=7, STEP=1, STEP_PERIODS=1, CNT_W=8):
1. Assert rst_n=0 mid-run with en=1 -> pwm_out=0000, ramp_val=1, period_tick=0 asynchronously. After release, period_tick first pulses 10 clks later.
2. STAGGER=0, ch0 STATIC duty_in=3 -> after first boundary, pwm_out[0] high exactly 3 of every 10 clks, rising 1 clk after cnt=0.
3. Change duty_in from 3 to 6 at cnt=4 -> current period keeps a 3-high pattern; the next period is 6 high.
4. ch0 BREATHE -> ramp_val per boundary: 2,3,4,5,6,7,6,5,4,3,2,1,2. pwm_out[0] high count per period equals the ramp value latched.
5. STAGGER=1 (PH=2), ch1 STATIC duty 5 -> pwm_out[1] high while cnt in {0,1,2,8,9} (shifted by 1 clk latency); ch0 high for cnt 0..4.
6. ch2 FULL and ch3 STATIC duty_in=200 -> both constant high. Drop en for 7 clks -> all outputs low, ramp_val and cnt frozen. Raise en -> resumes from the held cnt with the same ramp value.
